divider_flow_ctrl: RTL and testbench
====================================

DIVIDER_FLOW_CTRL -- requirements
Module: divider_flow_ctrl

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 8: operand/quotient width; divider pipeline latency is LATENCY = DIVIDEND_WIDTH cycles.
REQ-002 SHALL have parameter DIVIDER_WIDTH, default 8: divisor/remainder width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: result FIFO entries, power of two, >= 2.
REQ-004 SHALL use one clock and a synchronous, active-low reset: in_clk input 1 rising-edge clock; in_rst_n input 1 synchronous active-low reset.
REQ-005 SHALL have these request ports: in_req_valid input 1 request valid; out_req_ready output 1 request accepted when high; in_req_dividend input DIVIDEND_WIDTH; in_req_divider input DIVIDER_WIDTH.
REQ-006 SHALL have these divider-side ports: out_div_valid output 1; out_div_dividend output DIVIDEND_WIDTH; out_div_divider output DIVIDER_WIDTH; in_div_valid input 1; in_div_quotient input DIVIDEND_WIDTH; in_div_remainder input DIVIDER_WIDTH.
REQ-007 SHALL have these response ports: out_rsp_valid output 1; in_rsp_ready input 1; out_rsp_quotient output DIVIDEND_WIDTH; out_rsp_remainder output DIVIDER_WIDTH; out_rsp_div_zero output 1.
REQ-008 SHALL have these status ports: out_fifo_level output $clog2(FIFO_DEPTH)+1 FIFO occupancy; out_err output 1 sticky protocol error.

Function
REQ-009 SHALL set out_req_ready = (inflight_cnt + fifo_count < FIFO_DEPTH), decoded from registers only, with no combinational path from in_req_valid or in_rsp_ready.
REQ-010 SHALL issue on in_req_valid && out_req_ready, driving out_div_valid/out_div_dividend/out_div_divider registered one cycle later; out_div_valid SHALL be 0 in every non-issue cycle.
REQ-011 SHALL count inflight_cnt +1 per issue and -1 per accepted in_div_valid, with net 0 on the same cycle.
REQ-012 SHALL write the divider result into the FIFO on in_div_valid; the credit rule guarantees space, so no overflow path is needed.
REQ-013 SHALL drive out_rsp_valid = (fifo_count != 0) with response data taken from the FIFO head register; a written entry becomes visible the cycle after the write (no fall-through).
REQ-014 SHALL pop the FIFO on out_rsp_valid && in_rsp_ready; a simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 SHALL hold response data stable while out_rsp_valid && !in_rsp_ready.
REQ-016 SHALL set out_err and keep it set until reset when in_div_valid arrives with inflight_cnt == 0 outside the drain window; such a result SHALL be discarded.
REQ-017 SHALL keep out_err at 0 on any request/response ordering that obeys the handshakes.

Reset
REQ-018 SHALL clear on in_rst_n low at the clock edge: inflight_cnt, FIFO pointers/count, out_div_valid, out_err, and the zero-flag delay line; out_req_ready SHALL then be 1, and out_rsp_valid, out_rsp_div_zero and out_fifo_level SHALL be 0.
REQ-019 SHALL open a drain window of LATENCY+1 cycles after reset deassertion, during which in_div_valid is ignored with no FIFO write and no error, because the divider pipeline has no reset.
REQ-020 SHALL keep out_req_ready at 0 during the drain window.

Configuration
REQ-021 With DIVIDER_FLOW_DIV0_CHECK_EN defined, the block SHALL detect in_req_divider == 0 at issue and track the flag through a LATENCY-stage shift register aligned to in_div_valid.
REQ-022 With DIVIDER_FLOW_DIV0_CHECK_EN defined, a flagged result SHALL be stored as quotient all-ones, remainder 0, div_zero 1.
REQ-023 Without DIVIDER_FLOW_DIV0_CHECK_EN, out_rsp_div_zero SHALL be tied 0, the raw divider result SHALL be stored, and no flag delay line SHALL exist.

Structure
REQ-024 SHALL place the LATENCY derivation, the divide-by-zero substitution constants and the level width function in shared package divider_pkg.
REQ-025 SHALL implement the result storage as sub-module divider_result_fifo (synchronous FIFO with count and registered head), instantiated once.

Verification
REQ-026 Reset, wait 9 cycles, then one request 200/7 -> out_div_valid is 1 for one cycle; a divider model returns 28 r4 after 8 cycles; response 28/4/0 appears one cycle after in_div_valid.
REQ-027 Default parameters, in_rsp_ready=0, 20 back-to-back requests -> exactly 16 accepted; out_req_ready falls when inflight+level=16; out_fifo_level reaches 16; out_err stays 0.
REQ-028 Full FIFO, then in_rsp_ready=1 with continuous requests -> one pop and one accept per cycle in steady state; results leave in issue order.
REQ-029 With DIVIDER_FLOW_DIV0_CHECK_EN defined, request 55/0 -> response quotient 0xFF, remainder 0, div_zero 1; without the macro, div_zero is 0 and the raw model output is returned.
REQ-030 Inject in_div_valid with nothing in flight after the drain window -> out_err=1, level unchanged; the same injection at cycle 3 after reset -> ignored, out_err=0.
REQ-031 Assert reset with 5 requests in flight -> after the drain window level=0, out_err=0, and a fresh request completes correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared constants and helpers for the divider flow controller and its result FIFO.
package divider_pkg;

  typedef enum logic {
    FLOW_DRAIN = 1'b0,
    FLOW_RUN   = 1'b1
  } flow_state_e;

  // Values substituted for a divide-by-zero result; sliced to the operand widths.
  localparam logic [63:0] DIV0_QUOTIENT  = '1;
  localparam logic [63:0] DIV0_REMAINDER = '0;

  // The external divider resolves one quotient bit per cycle.
  function automatic int latency_of(input int dividend_width);
    return dividend_width;
  endfunction

  // Wide enough to hold every value from 0 up to and including depth.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/divider_result_fifo.sv
// Synchronous result FIFO with occupancy count and a registered head entry.
module divider_result_fifo
  import divider_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head_data,
  output logic [level_width(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = level_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_next;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] head_q;
  logic              pop_ok;

  assign rd_next   = rd_ptr_q + PTR_W'(1);
  assign pop_ok    = pop && (count_q != '0);
  assign head_data = head_q;
  assign count     = count_q;

  always_ff @(posedge in_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // The head register always mirrors mem_q[rd_ptr_q] one cycle after it changes.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_next;
      end
      if (push && !pop_ok) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_ok && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (pop_ok) begin
        head_q <= (count_q == CNT_W'(1)) ? push_data : mem_q[rd_next];
      end else if (push && (count_q == '0)) begin
        head_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/divider_flow_ctrl.sv
// Credit-based flow control around a fixed-latency, non-resettable divider.
// Optional divide-by-zero tracking is enabled by DIVIDER_FLOW_DIV0_CHECK_EN.
//
// state      | meaning
// FLOW_DRAIN | after reset: divider outputs ignored, no requests accepted
// FLOW_RUN   | normal issue / return / response operation
module divider_flow_ctrl
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVIDER_WIDTH  = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                               in_clk,
  input  logic                               in_rst_n,
  input  logic                               in_req_valid,
  output logic                               out_req_ready,
  input  logic [DIVIDEND_WIDTH-1:0]          in_req_dividend,
  input  logic [DIVIDER_WIDTH-1:0]           in_req_divider,
  output logic                               out_div_valid,
  output logic [DIVIDEND_WIDTH-1:0]          out_div_dividend,
  output logic [DIVIDER_WIDTH-1:0]           out_div_divider,
  input  logic                               in_div_valid,
  input  logic [DIVIDEND_WIDTH-1:0]          in_div_quotient,
  input  logic [DIVIDER_WIDTH-1:0]           in_div_remainder,
  output logic                               out_rsp_valid,
  input  logic                               in_rsp_ready,
  output logic [DIVIDEND_WIDTH-1:0]          out_rsp_quotient,
  output logic [DIVIDER_WIDTH-1:0]           out_rsp_remainder,
  output logic                               out_rsp_div_zero,
  output logic [level_width(FIFO_DEPTH)-1:0] out_fifo_level,
  output logic                               out_err
);

  localparam int LATENCY = latency_of(DIVIDEND_WIDTH);
  localparam int LVL_W   = level_width(FIFO_DEPTH);
  localparam int DRAIN_W = $clog2(LATENCY + 2);
  localparam logic [LVL_W:0] CREDITS = (LVL_W + 1)'(FIFO_DEPTH);
`ifdef DIVIDER_FLOW_DIV0_CHECK_EN
  localparam int DATA_W = DIVIDEND_WIDTH + DIVIDER_WIDTH + 1;
`else
  localparam int DATA_W = DIVIDEND_WIDTH + DIVIDER_WIDTH;
`endif

  flow_state_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [LVL_W-1:0]   inflight_q;
  logic [LVL_W-1:0]   fifo_count;
  logic [LVL_W:0]     credit_used;
  logic               running;
  logic               issue;
  logic               div_accept;
  logic               div_stray;
  logic               rsp_pop;
  logic [DATA_W-1:0]  fifo_wdata;
  logic [DATA_W-1:0]  fifo_head;

  // Drain timer loads LATENCY at reset and runs down to zero: LATENCY+1 cycles.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q     <= FLOW_DRAIN;
      drain_cnt_q <= DRAIN_W'(LATENCY);
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      FLOW_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = FLOW_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      FLOW_RUN: state_d = FLOW_RUN;
      default:  state_d = FLOW_DRAIN;
    endcase
  end

  assign running       = (state_q == FLOW_RUN);
  assign credit_used   = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign out_req_ready = running && (credit_used < CREDITS);
  assign issue         = in_req_valid && out_req_ready;
  assign div_accept    = in_div_valid && running && (inflight_q != '0);
  assign div_stray     = in_div_valid && running && (inflight_q == '0);
  assign out_rsp_valid = (fifo_count != '0);
  assign rsp_pop       = out_rsp_valid && in_rsp_ready;
  assign out_fifo_level = fifo_count;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      inflight_q    <= '0;
      out_div_valid <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      out_div_valid <= issue;
      if (issue && !div_accept) begin
        inflight_q <= inflight_q + LVL_W'(1);
      end else if (div_accept && !issue) begin
        inflight_q <= inflight_q - LVL_W'(1);
      end
      if (div_stray) begin
        out_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (issue) begin
      out_div_dividend <= in_req_dividend;
      out_div_divider  <= in_req_divider;
    end
  end

`ifdef DIVIDER_FLOW_DIV0_CHECK_EN
  logic               div0_issue_q;
  logic [LATENCY-1:0] div0_pipe_q;
  logic               div0_hit;

  // Flag rides alongside out_div_valid, then LATENCY stages to meet in_div_valid.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      div0_issue_q <= 1'b0;
      div0_pipe_q  <= '0;
    end else begin
      div0_issue_q <= issue && (in_req_divider == '0);
      div0_pipe_q  <= (div0_pipe_q << 1) | LATENCY'(div0_issue_q);
    end
  end

  assign div0_hit   = div0_pipe_q[LATENCY-1];
  assign fifo_wdata = div0_hit
                    ? {DIV0_QUOTIENT[DIVIDEND_WIDTH-1:0], DIV0_REMAINDER[DIVIDER_WIDTH-1:0], 1'b1}
                    : {in_div_quotient, in_div_remainder, 1'b0};
  assign {out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero} = fifo_head;
`else
  assign fifo_wdata       = {in_div_quotient, in_div_remainder};
  assign {out_rsp_quotient, out_rsp_remainder} = fifo_head;
  assign out_rsp_div_zero = 1'b0;
`endif

  divider_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_result_fifo (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .push      (div_accept),
    .push_data (fifo_wdata),
    .pop       (rsp_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_divider_flow_ctrl.sv
// Directed bench for divider_flow_ctrl with an 8-cycle divider pipeline model.
module tb_divider_flow_ctrl;
  localparam int LAT = 8;

  logic       in_clk = 1'b0;
  logic       in_rst_n = 1'b0;
  logic       in_req_valid = 1'b0;
  logic       out_req_ready;
  logic [7:0] in_req_dividend = '0;
  logic [7:0] in_req_divider = '0;
  logic       out_div_valid;
  logic [7:0] out_div_dividend;
  logic [7:0] out_div_divider;
  logic       in_div_valid;
  logic [7:0] in_div_quotient;
  logic [7:0] in_div_remainder;
  logic       out_rsp_valid;
  logic       in_rsp_ready = 1'b0;
  logic [7:0] out_rsp_quotient;
  logic [7:0] out_rsp_remainder;
  logic       out_rsp_div_zero;
  logic [4:0] out_fifo_level;
  logic       out_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
  } exp_t;
  exp_t exp_q[$];

  always #5 in_clk = ~in_clk;

  divider_flow_ctrl dut (
    .in_clk            (in_clk),
    .in_rst_n          (in_rst_n),
    .in_req_valid      (in_req_valid),
    .out_req_ready     (out_req_ready),
    .in_req_dividend   (in_req_dividend),
    .in_req_divider    (in_req_divider),
    .out_div_valid     (out_div_valid),
    .out_div_dividend  (out_div_dividend),
    .out_div_divider   (out_div_divider),
    .in_div_valid      (in_div_valid),
    .in_div_quotient   (in_div_quotient),
    .in_div_remainder  (in_div_remainder),
    .out_rsp_valid     (out_rsp_valid),
    .in_rsp_ready      (in_rsp_ready),
    .out_rsp_quotient  (out_rsp_quotient),
    .out_rsp_remainder (out_rsp_remainder),
    .out_rsp_div_zero  (out_rsp_div_zero),
    .out_fifo_level    (out_fifo_level),
    .out_err           (out_err)
  );

  // Divider model: no reset, result appears LAT cycles after out_div_valid.
  logic       pv [LAT];
  logic [7:0] pq [LAT];
  logic [7:0] pr [LAT];
  logic       inj_valid = 1'b0;
  logic [7:0] inj_q = '0;
  logic [7:0] inj_r = '0;

  always @(posedge in_clk) begin
    pv[0] <= out_div_valid;
    pq[0] <= (out_div_divider == 0) ? 8'hFF : out_div_dividend / out_div_divider;
    pr[0] <= (out_div_divider == 0) ? out_div_dividend : out_div_dividend % out_div_divider;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pq[i] <= pq[i-1];
      pr[i] <= pr[i-1];
    end
  end

  assign in_div_valid     = inj_valid | pv[LAT-1];
  assign in_div_quotient  = inj_valid ? inj_q : pq[LAT-1];
  assign in_div_remainder = inj_valid ? inj_r : pr[LAT-1];

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst_n     = 1'b0;
    in_req_valid = 1'b0;
    in_rsp_ready = 1'b0;
    inj_valid    = 1'b0;
    repeat (2) tick();
    in_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0b want 0", out_rsp_valid); end
    n_vec++; if (out_rsp_div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero got %0b want 0", out_rsp_div_zero); end
    n_vec++; if (out_fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", out_fifo_level); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", out_err); end
    n_vec++; if (out_div_valid !== 1'b0) begin n_err++; $display("FAIL reset_div_valid got %0b want 0", out_div_valid); end
    repeat (LAT) tick();
    n_vec++; if (out_req_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready got %0b want 0", out_req_ready); end
    tick();
    n_vec++; if (out_req_ready !== 1'b1) begin n_err++; $display("FAIL post_drain_ready got %0b want 1", out_req_ready); end
  endtask

  task automatic test_single();
    int n;
    in_req_valid = 1'b1; in_req_dividend = 8'd200; in_req_divider = 8'd7;
    tick();
    in_req_valid = 1'b0;
    n_vec++; if (out_div_valid !== 1'b1) begin n_err++; $display("FAIL issue_valid got %0b want 1", out_div_valid); end
    n_vec++; if ({out_div_dividend, out_div_divider} !== {8'd200, 8'd7}) begin n_err++; $display("FAIL issue_operands got %0d/%0d want 200/7", out_div_dividend, out_div_divider); end
    tick();
    n_vec++; if (out_div_valid !== 1'b0) begin n_err++; $display("FAIL issue_one_cycle got %0b want 0", out_div_valid); end
    n = 1;
    while (!in_div_valid && n < 20) begin tick(); n++; end
    n_vec++; if (n !== LAT) begin n_err++; $display("FAIL div_latency got %0d want %0d", n, LAT); end
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL no_fall_through got %0b want 0", out_rsp_valid); end
    tick();
    n_vec++; if ({out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero} !== {1'b1, 8'd28, 8'd4, 1'b0})
      begin n_err++; $display("FAIL single_rsp got v%0b %0d r%0d z%0b want v1 28 r4 z0", out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero); end
    n_vec++; if (out_fifo_level !== 5'd1) begin n_err++; $display("FAIL single_level got %0d want 1", out_fifo_level); end
    tick();
    n_vec++; if ({out_rsp_valid, out_rsp_quotient, out_rsp_remainder} !== {1'b1, 8'd28, 8'd4})
      begin n_err++; $display("FAIL hold_rsp got v%0b %0d r%0d want v1 28 r4", out_rsp_valid, out_rsp_quotient, out_rsp_remainder); end
    in_rsp_ready = 1'b1;
    tick();
    in_rsp_ready = 1'b0;
    n_vec++; if ({out_rsp_valid, out_fifo_level} !== {1'b0, 5'd0}) begin n_err++; $display("FAIL single_pop got v%0b lvl %0d want v0 lvl 0", out_rsp_valid, out_fifo_level); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int last_c = -1;
    exp_t e;
    in_rsp_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_req_valid    = (acc < 20);
      in_req_dividend = 8'(10 + acc);
      in_req_divider  = 8'd3;
      if (in_req_valid && out_req_ready) begin
        e.q = 8'((10 + acc) / 3);
        e.r = 8'((10 + acc) % 3);
        exp_q.push_back(e);
        acc++;
        last_c = c;
      end
      tick();
    end
    in_req_valid = 1'b0;
    n_vec++; if (acc !== 16) begin n_err++; $display("FAIL bp_accepted got %0d want 16", acc); end
    n_vec++; if (last_c !== 15) begin n_err++; $display("FAIL bp_last_accept_cycle got %0d want 15", last_c); end
    n_vec++; if (out_fifo_level !== 5'd16) begin n_err++; $display("FAIL bp_level got %0d want 16", out_fifo_level); end
    n_vec++; if (out_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %0b want 0", out_req_ready); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL bp_err got %0b want 0", out_err); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int pops = 0;
    exp_t e;
    in_rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_req_valid    = 1'b1;
      in_req_dividend = 8'(37 * c + 5);
      in_req_divider  = 8'(c % 13 + 1);
      if (out_req_ready) begin
        e.q = in_req_dividend / in_req_divider;
        e.r = in_req_dividend % in_req_divider;
        exp_q.push_back(e);
        acc++;
      end
      if (out_rsp_valid) begin
        pops++;
        e = exp_q.pop_front();
        n_vec++; if ({out_rsp_quotient, out_rsp_remainder} !== {e.q, e.r})
          begin n_err++; $display("FAIL b2b_order got %0d r%0d want %0d r%0d", out_rsp_quotient, out_rsp_remainder, e.q, e.r); end
      end
      tick();
    end
    in_req_valid = 1'b0;
    n_vec++; if (acc !== 39) begin n_err++; $display("FAIL b2b_accepts got %0d want 39", acc); end
    n_vec++; if (pops !== 40) begin n_err++; $display("FAIL b2b_pops got %0d want 40", pops); end
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      if (out_rsp_valid) begin
        e = exp_q.pop_front();
        n_vec++; if ({out_rsp_quotient, out_rsp_remainder} !== {e.q, e.r})
          begin n_err++; $display("FAIL drain_order got %0d r%0d want %0d r%0d", out_rsp_quotient, out_rsp_remainder, e.q, e.r); end
      end
      tick();
    end
    in_rsp_ready = 1'b0;
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL drain_left got %0d want 0", exp_q.size()); end
    n_vec++; if ({out_fifo_level, out_err} !== {5'd0, 1'b0}) begin n_err++; $display("FAIL drain_end got lvl %0d err %0b want 0 0", out_fifo_level, out_err); end
  endtask

  task automatic test_div_zero();
    int n = 0;
    in_req_valid = 1'b1; in_req_dividend = 8'd55; in_req_divider = 8'd0;
    tick();
    in_req_valid = 1'b0;
    while (!out_rsp_valid && n < 20) begin tick(); n++; end
`ifdef DIVIDER_FLOW_DIV0_CHECK_EN
    n_vec++; if ({out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero} !== {1'b1, 8'hFF, 8'd0, 1'b1})
      begin n_err++; $display("FAIL div0_rsp got v%0b %h r%0d z%0b want v1 ff r0 z1", out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero); end
`else
    n_vec++; if ({out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero} !== {1'b1, 8'hFF, 8'd55, 1'b0})
      begin n_err++; $display("FAIL div0_raw got v%0b %h r%0d z%0b want v1 ff r55 z0", out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_rsp_div_zero); end
`endif
    in_rsp_ready = 1'b1;
    tick();
    in_rsp_ready = 1'b0;
    n_vec++; if (out_fifo_level !== 5'd0) begin n_err++; $display("FAIL div0_pop got %0d want 0", out_fifo_level); end
  endtask

  task automatic test_stray();
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL stray_pre_err got %0b want 0", out_err); end
    inj_valid = 1'b1; inj_q = 8'd1; inj_r = 8'd1;
    tick();
    inj_valid = 1'b0;
    n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL stray_err got %0b want 1", out_err); end
    n_vec++; if ({out_fifo_level, out_rsp_valid} !== {5'd0, 1'b0}) begin n_err++; $display("FAIL stray_discard got lvl %0d v%0b want 0 0", out_fifo_level, out_rsp_valid); end
    tick();
    n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL stray_sticky got %0b want 1", out_err); end
    do_reset();
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL stray_reset_clear got %0b want 0", out_err); end
    repeat (3) tick();
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (LAT + 1 - 4) tick();
    n_vec++; if ({out_err, out_fifo_level, out_req_ready} !== {1'b0, 5'd0, 1'b1})
      begin n_err++; $display("FAIL drain_inject got err %0b lvl %0d rdy %0b want 0 0 1", out_err, out_fifo_level, out_req_ready); end
  endtask

  task automatic test_reset_inflight();
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      in_req_valid = 1'b1; in_req_dividend = 8'(50 + i); in_req_divider = 8'd3;
      tick();
    end
    in_req_valid = 1'b0;
    tick();
    do_reset();
    repeat (LAT + 1) tick();
    n_vec++; if ({out_fifo_level, out_err, out_rsp_valid} !== {5'd0, 1'b0, 1'b0})
      begin n_err++; $display("FAIL rst_inflight got lvl %0d err %0b v%0b want 0 0 0", out_fifo_level, out_err, out_rsp_valid); end
    in_req_valid = 1'b1; in_req_dividend = 8'd100; in_req_divider = 8'd9;
    tick();
    in_req_valid = 1'b0;
    while (!out_rsp_valid && n < 20) begin tick(); n++; end
    n_vec++; if ({out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_fifo_level, out_err} !== {1'b1, 8'd11, 8'd1, 5'd1, 1'b0})
      begin n_err++; $display("FAIL fresh_rsp got v%0b %0d r%0d lvl %0d err %0b want v1 11 r1 lvl 1 err 0", out_rsp_valid, out_rsp_quotient, out_rsp_remainder, out_fifo_level, out_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_div_zero();
    test_stray();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
